// File: rtl/deserializer.sv
// Serial-to-parallel receiver: packs MSB-first bits into W-bit words and
// flushes partial bursts left-aligned with a length code (0 = full word).
module deserializer #(
  parameter int W             = 16,
  parameter bit FLUSH_PARTIAL = 1'b1,
  parameter int MODW          = $clog2(W)
) (
  input  logic            clk_i,
  input  logic            srst_i,
  input  logic            data_i,
  input  logic            data_val_i,
  output logic [W-1:0]    deser_data_o,
  output logic [MODW-1:0] deser_data_mod_o,
  output logic            deser_data_val_o,
  output logic            short_burst_o
);

  // Input side: a bit is consumed on every edge where data_val_i is high
  // (no ready, never stalled). Output side: deser_data_val_o is a one-cycle
  // strobe with no backpressure; data/mod are meaningful only while it is high.

  logic [MODW-1:0] cnt;
  logic [W-1:0]    sr;

  logic            full_c;
  logic            burst_end_c;
  logic            short_c;
  logic            flush_c;
  logic [W-1:0]    word_c;
  logic [MODW:0]   align_sh_c;
  logic [W-1:0]    left_c;

  always_comb begin
    full_c      = data_val_i && (cnt == MODW'(W - 1));
    burst_end_c = !data_val_i && (cnt != '0);
    short_c     = burst_end_c && (cnt <= MODW'(2));
    flush_c     = burst_end_c && !short_c && FLUSH_PARTIAL;
    word_c      = {sr[W-2:0], data_i};
    // Received bits sit in the low cnt positions; move them up to [W-1].
    align_sh_c  = (MODW + 1)'(W) - {1'b0, cnt};
    left_c      = sr << align_sh_c;
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      cnt              <= '0;
      sr               <= '0;
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
      short_burst_o    <= 1'b0;
    end else begin
      deser_data_val_o <= full_c || flush_c;
      short_burst_o    <= short_c;
      if (full_c) begin
        deser_data_o     <= word_c;
        deser_data_mod_o <= '0;
        cnt              <= '0;
        sr               <= '0;
      end else if (data_val_i) begin
        sr  <= word_c;
        cnt <= cnt + 1'b1;
      end else if (burst_end_c) begin
        // Emitted or discarded, the burst's bits must not leak into the next word.
        if (flush_c) begin
          deser_data_o     <= left_c;
          deser_data_mod_o <= cnt;
        end
        cnt <= '0;
        sr  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: two instances (flush on / flush off) share one
// bit stream and are compared each cycle against a burst-level reference.
module tb_deserializer;

  localparam int W    = 16;
  localparam int MODW = $clog2(W);

  logic            clk_i = 1'b0;
  logic            srst_i;
  logic            data_i;
  logic            data_val_i;
  logic [W-1:0]    data1, data0;
  logic [MODW-1:0] mod1, mod0;
  logic            val1, val0;
  logic            short1, short0;

  int checks = 0;
  int errors = 0;

  // reference: current burst as an integer plus its length
  longint          acc = 0;
  int              len = 0;
  logic            exp_v1, exp_v0, exp_s;
  logic [W-1:0]    exp_q1[$];
  logic [W-1:0]    exp_q0[$];
  logic [MODW-1:0] mod_q1[$];
  logic [W-1:0]    last_word1;
  logic [MODW-1:0] last_mod1;
  int              strobes0 = 0;

  always #5 clk_i = ~clk_i;

  deserializer #(.W(W), .FLUSH_PARTIAL(1'b1)) dut1 (
    .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .deser_data_o(data1), .deser_data_mod_o(mod1),
    .deser_data_val_o(val1), .short_burst_o(short1)
  );

  deserializer #(.W(W), .FLUSH_PARTIAL(1'b0)) dut0 (
    .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .deser_data_o(data0), .deser_data_mod_o(mod0),
    .deser_data_val_o(val0), .short_burst_o(short0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict what both instances must show after the coming edge.
  task automatic model_step(input logic rst_n, input logic v, input logic d);
    exp_v1 = 1'b0;
    exp_v0 = 1'b0;
    exp_s  = 1'b0;
    if (!rst_n) begin
      acc = 0;
      len = 0;
    end else if (v) begin
      acc = acc * 2 + longint'(d);
      len++;
      if (len == W) begin
        exp_v1 = 1'b1;
        exp_v0 = 1'b1;
        exp_q1.push_back(W'(acc));
        mod_q1.push_back('0);
        exp_q0.push_back(W'(acc));
        acc = 0;
        len = 0;
      end
    end else if (len > 0) begin
      if (len <= 2) begin
        exp_s = 1'b1;
      end else begin
        exp_v1 = 1'b1;
        exp_q1.push_back(W'(acc * (longint'(1) << (W - len))));
        mod_q1.push_back(MODW'(len));
      end
      acc = 0;
      len = 0;
    end
  endtask

  // One clock: drive after the falling edge, check after the next falling edge.
  task automatic cycle(input logic rst_n, input logic v, input logic d);
    logic [W-1:0]    w;
    logic [MODW-1:0] m;
    srst_i     = rst_n;
    data_val_i = v;
    data_i     = d;
    model_step(rst_n, v, d);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("val_flush1", 32'(val1), 32'(exp_v1));
    chk("val_flush0", 32'(val0), 32'(exp_v0));
    chk("short_flush1", 32'(short1), 32'(exp_s));
    chk("short_flush0", 32'(short0), 32'(exp_s));
    if (exp_v1) begin
      w = exp_q1.pop_front();
      m = mod_q1.pop_front();
      chk("data_flush1", 32'(data1), 32'(w));
      chk("mod_flush1", 32'(mod1), 32'(m));
      last_word1 = data1;
      last_mod1  = mod1;
    end
    if (exp_v0) begin
      w = exp_q0.pop_front();
      chk("data_flush0", 32'(data0), 32'(w));
      chk("mod_flush0", 32'(mod0), 32'(0));
    end
    if (val0) strobes0++;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) cycle(1'b1, 1'b1, w[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int s0;
    logic [4:0] five;
    srst_i     = 1'b0;
    data_val_i = 1'b0;
    data_i     = 1'b0;
    @(negedge clk_i);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("reset_data1", 32'(data1), 32'(0));
    chk("reset_mod1", 32'(mod1), 32'(0));
    chk("reset_data0", 32'(data0), 32'(0));

    // full word, 1-cycle latency checked by the per-cycle strobe compare
    send_word(16'hA5C3);
    chk("word_a5c3", 32'(last_word1), 32'h0000A5C3);
    idle(2);

    // back-to-back words, zero bubbles
    send_word(16'hFFFF);
    send_word(16'h0001);
    chk("b2b_second", 32'(last_word1), 32'h00000001);
    idle(2);

    // 5-bit partial burst
    s0   = strobes0;
    five = 5'b11011;
    for (int i = 4; i >= 0; i--) cycle(1'b1, 1'b1, five[i]);
    idle(2);
    chk("partial_word", 32'(last_word1), 32'h0000D800);
    chk("partial_mod", 32'(last_mod1), 32'd5);
    chk("partial_no_flush0", 32'(strobes0), 32'(s0));

    // 2-bit short burst, then a clean word
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    idle(1);
    send_word(16'h5A5A);
    chk("after_short", 32'(last_word1), 32'h00005A5A);
    idle(2);

    // reset in the middle of a word
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)));
    cycle(1'b0, 1'b0, 1'b0);
    send_word(16'h1234);
    chk("after_reset", 32'(last_word1), 32'h00001234);
    idle(2);

    // random stream with gaps inside words
    for (int i = 0; i < 600; i++)
      cycle(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    idle(2);

    // gap-free random bursts of random length
    for (int b = 0; b < 60; b++) begin
      int n;
      n = $urandom_range(1, 3 * W);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      idle($urandom_range(1, 3));
    end

    chk("q1_drained", 32'(exp_q1.size()), 32'(0));
    chk("q0_drained", 32'(exp_q0.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
